// File: rtl/repeat_seq_checker_if.sv
// Sample stream into the repeated-count checker and its status/error outputs.
interface repeat_seq_checker_if #(
  parameter int N = 4
);
  logic         en;
  logic [N-1:0] din;
  logic         locked;
  logic         step;
  logic         wrap;
  logic         err_pulse;
  logic [1:0]   err_code;
  logic [15:0]  err_count;

  modport master (
    output en, din,
    input  locked, step, wrap, err_pulse, err_code, err_count
  );

  modport slave (
    input  en, din,
    output locked, step, wrap, err_pulse, err_code, err_count
  );
endinterface

// File: rtl/repeat_seq_checker.sv
// Monitors a stream in which each value 0..MAX_CNT repeats REPEAT_LIMIT times:
// acquires run phase, locks after LOCK_STEPS good runs, then classifies errors.
module repeat_seq_checker #(
  parameter int REPEAT_LIMIT = 5,
  parameter int MAX_CNT      = 9,
  parameter int N            = 4,
  parameter int LOCK_STEPS   = 2
) (
  input logic                clk,
  input logic                rst,
  repeat_seq_checker_if.slave bus
);
  localparam int RCW = $clog2(REPEAT_LIMIT + 1);
  localparam int GW  = $clog2(LOCK_STEPS + 1);
  localparam logic [N-1:0]   MAX_V = N'(MAX_CNT);
  localparam logic [RCW-1:0] RL_V  = RCW'(REPEAT_LIMIT);
  localparam logic [GW-1:0]  LS_V  = GW'(LOCK_STEPS);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t         state_q;
  logic [N-1:0]   prev_q;
  logic [RCW-1:0] rc_q;
  logic [GW-1:0]  good_q;
  logic           phase_q;
  logic           ovl_q;
  logic           locked_q, step_q, wrap_q, err_pulse_q;
  logic [1:0]     err_code_q;
  logic [15:0]    err_count_q;

  logic [N-1:0]  succ_prev;
  logic          in_range, same, is_succ, rc_full;
  logic [GW-1:0] good_inc;
  logic [1:0]    lock_code;

  assign succ_prev = (prev_q == MAX_V) ? '0 : prev_q + 1'b1;
  assign in_range  = (bus.din <= MAX_V);
  assign same      = (bus.din == prev_q);
  assign is_succ   = (bus.din == succ_prev);
  assign rc_full   = (rc_q == RL_V);
  assign good_inc  = good_q + 1'b1;
  // Priority: a mid-run change is SHORT even if the new value is out of range.
  assign lock_code = !rc_full ? 2'd1 : (same ? 2'd2 : 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      rc_q        <= '0;
      good_q      <= '0;
      phase_q     <= 1'b0;
      ovl_q       <= 1'b0;
      locked_q    <= 1'b0;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 2'd0;
      err_count_q <= '0;
    end else begin
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      if (bus.en) begin
        unique case (state_q)
          IDLE: begin
            if (in_range) begin
              prev_q  <= bus.din;
              rc_q    <= RCW'(1);
              phase_q <= 1'b0;
              ovl_q   <= 1'b0;
              state_q <= ACQ;
            end
          end
          ACQ: begin
            if (!in_range) begin
              state_q <= IDLE;
              good_q  <= '0;
            end else if (same) begin
              // rc saturates; an overlong run disqualifies itself via ovl_q.
              if (rc_full) begin
                good_q <= '0;
                ovl_q  <= 1'b1;
              end else begin
                rc_q <= rc_q + 1'b1;
              end
            end else begin
              prev_q  <= bus.din;
              rc_q    <= RCW'(1);
              phase_q <= 1'b1;
              ovl_q   <= 1'b0;
              if (phase_q && rc_full && is_succ && !ovl_q) begin
                good_q <= good_inc;
                if (good_inc == LS_V) begin
                  state_q  <= LOCK;
                  locked_q <= 1'b1;
                end
              end else begin
                good_q <= '0;
              end
            end
          end
          LOCK: begin
            if (!rc_full && same) begin
              rc_q <= rc_q + 1'b1;
            end else if (rc_full && is_succ) begin
              rc_q   <= RCW'(1);
              prev_q <= bus.din;
              step_q <= 1'b1;
              wrap_q <= (prev_q == MAX_V);
            end else begin
              err_pulse_q <= 1'b1;
              err_code_q  <= lock_code;
              if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
              locked_q <= 1'b0;
              good_q   <= '0;
              if (in_range) begin
                state_q <= ACQ;
                prev_q  <= bus.din;
                rc_q    <= RCW'(1);
                phase_q <= !same;
                ovl_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.step      = step_q;
  assign bus.wrap      = wrap_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_repeat_seq_checker.sv
// Directed + random stimulus against a sample-level reference model of the checker.
module tb_repeat_seq_checker;
  localparam int RL   = 3;
  localparam int MAXC = 4;
  localparam int LS   = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode 0 idle, 1 acquiring, 2 locked; m_run is the true run length
  int m_mode, m_prev, m_run, m_good, m_phase;
  int m_locked, m_step, m_wrap, m_ep, m_code, m_cnt;

  repeat_seq_checker_if #(.N(3)) bus ();

  repeat_seq_checker #(
    .REPEAT_LIMIT(RL), .MAX_CNT(MAXC), .N(3), .LOCK_STEPS(LS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int succ(input int x);
    return (x == MAXC) ? 0 : x + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_good = 0; m_phase = 0;
    m_locked = 0; m_step = 0; m_wrap = 0; m_ep = 0; m_code = 0; m_cnt = 0;
  endtask

  task automatic model(input int e, input int d);
    int code;
    code = 0;
    m_step = 0; m_wrap = 0; m_ep = 0;
    if (e == 0) return;
    case (m_mode)
      0: if (d <= MAXC) begin
        m_mode = 1; m_prev = d; m_run = 1; m_phase = 0;
      end
      1: begin
        if (d > MAXC) begin
          m_mode = 0; m_good = 0;
        end else if (d == m_prev) begin
          m_run++;
          if (m_run > RL) m_good = 0;
        end else begin
          if (m_phase == 1 && m_run == RL && d == succ(m_prev)) m_good++;
          else m_good = 0;
          m_prev = d; m_run = 1; m_phase = 1;
          if (m_good == LS) begin m_mode = 2; m_locked = 1; end
        end
      end
      default: begin
        if (m_run < RL && d == m_prev) m_run++;
        else if (m_run < RL) code = 1;
        else if (d == m_prev) code = 2;
        else if (d == succ(m_prev)) begin
          m_step = 1; m_wrap = (m_prev == MAXC) ? 1 : 0; m_prev = d; m_run = 1;
        end else code = 3;
        if (code != 0) begin
          m_ep = 1; m_code = code;
          if (m_cnt < 65535) m_cnt++;
          m_locked = 0; m_good = 0;
          if (d <= MAXC) begin
            m_mode = 1; m_phase = (d != m_prev) ? 1 : 0; m_prev = d; m_run = 1;
          end else m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    total++;
    assert (got === 32'(exp)) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".locked"}, 32'(bus.locked),    m_locked);
    chk({tag, ".step"},   32'(bus.step),      m_step);
    chk({tag, ".wrap"},   32'(bus.wrap),      m_wrap);
    chk({tag, ".err_p"},  32'(bus.err_pulse), m_ep);
    chk({tag, ".code"},   32'(bus.err_code),  m_code);
    chk({tag, ".count"},  32'(bus.err_count), m_cnt);
  endtask

  task automatic smp(input int e, input int d);
    bus.en  = e[0];
    bus.din = d[2:0];
    model(e, d);
    @(posedge clk);
    #1;
    chk_all(e != 0 ? "smp" : "idle_cyc");
  endtask

  task automatic run(input int v, input int n);
    for (int i = 0; i < n; i++) smp(1, v);
  endtask

  task automatic gate(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      smp(1, v);
      smp(0, int'($urandom_range(7, 0)));
    end
  endtask

  task automatic do_rst();
    bus.en  = 1'b1;
    bus.din = 3'd2;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk_all("reset");
  endtask

  task automatic lock_seq();
    run(0, 3); run(1, 3); run(2, 3); run(3, 1);
  endtask

  initial begin
    int gv, gn, dv;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("por");
    rst = 1'b0;

    // Lock acquisition on the 10th sample
    run(0, 3); run(1, 3); run(2, 3);
    chk("pre_lock", 32'(bus.locked), 0);
    run(3, 1);
    chk("lock_rise", 32'(bus.locked), 1);

    // Steady stream through the wrap
    run(3, 2); run(4, 3); run(0, 1);
    chk("wrap_pulse", 32'(bus.wrap), 1);
    run(0, 2); run(1, 1);
    chk("steady_cnt", 32'(bus.err_count), 0);

    // SHORT, LONG, VALUE in turn, relocking in between
    smp(1, 2);
    chk("short_code", 32'(bus.err_code), 1);
    run(2, 2); run(3, 3); run(4, 1);
    run(4, 2); smp(1, 4);
    chk("long_code", 32'(bus.err_code), 2);
    run(0, 3); run(1, 3); run(2, 1);
    run(2, 2); smp(1, 4);
    chk("value_code", 32'(bus.err_code), 3);
    chk("three_errs", 32'(bus.err_count), 3);

    // Out-of-range value while locked, then relock from scratch
    run(4, 2); run(0, 3); run(1, 1);
    run(1, 2); smp(1, 7);
    chk("oor_code", 32'(bus.err_code), 3);
    run(2, 3); run(3, 3); run(4, 3);
    chk("oor_no_lock", 32'(bus.locked), 0);
    run(0, 1);
    chk("oor_relock", 32'(bus.locked), 1);

    // en gating: only en=1 samples count towards a run
    gate(0, 2); gate(1, 3); gate(2, 3);
    chk("gate_locked", 32'(bus.locked), 1);
    chk("gate_cnt", 32'(bus.err_count), 4);

    // Reset while locked
    do_rst();

    // Random stream with occasional corruption and en gaps
    gv = 0; gn = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(4, 0) == 0) begin
        smp(0, int'($urandom_range(7, 0)));
      end else if ($urandom_range(29, 0) == 0) begin
        smp(1, int'($urandom_range(7, 0)));
      end else begin
        dv = gv;
        gn++;
        if (gn >= RL || $urandom_range(59, 0) == 0) begin
          gn = 0;
          gv = succ(gv);
        end
        smp(1, dv);
      end
    end

    // Saturation: preload the counter near the top, then keep erroring
    do_rst();
    lock_seq();
    force dut.err_count_q = 16'hFFFD;
    #1;
    release dut.err_count_q;
    m_cnt = 65533;
    smp(1, 4);
    chk("sat_m1", 32'(bus.err_count), 65534);
    run(4, 2); run(0, 3); run(1, 1);
    smp(1, 3);
    chk("sat_top", 32'(bus.err_count), 65535);
    run(3, 2); run(4, 3); run(0, 1);
    smp(1, 2);
    chk("sat_hold", 32'(bus.err_count), 65535);
    chk("sat_pulse", 32'(bus.err_pulse), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
